// File: rtl/lv_owt_pkg.sv
// Shared definitions for the one-wire register access path: FSM states,
// frame command encoding and default timing/retry limits.
package lv_owt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } owt_state_e;

  localparam logic OWT_CMD_WR = 1'b1;
  localparam logic OWT_CMD_RD = 1'b0;

  localparam int unsigned OWT_TMO_CYC_DEF   = 1023;
  localparam int unsigned OWT_RETRY_NUM_DEF = 2;

endpackage

// File: rtl/lv_owt_tmo_cnt.sv
// Response timeout counter: counts while enabled, saturates at TMO_CYC-1 and
// flags timeout while enabled at that value.
module lv_owt_tmo_cnt
  import lv_owt_pkg::*;
#(
  parameter int unsigned TMO_CYC = OWT_TMO_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = enable && (cnt == LAST);

endmodule

// File: rtl/lv_owt_access_rsp.sv
// SPI-side register access to one-wire frame requester with response check,
// timeout and optional retry (enabled by defining LV_OWT_RETRY_EN).
module lv_owt_access_rsp
  import lv_owt_pkg::*;
#(
  parameter int unsigned REG_AW    = 7,
  parameter int unsigned REG_DW    = 8,
  parameter int unsigned TMO_CYC   = OWT_TMO_CYC_DEF,
  parameter int unsigned RETRY_NUM = OWT_RETRY_NUM_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_owt_wr_req,
  input  logic              i_spi_owt_rd_req,
  input  logic [REG_AW-1:0] i_spi_owt_addr,
  input  logic [REG_DW-1:0] i_spi_owt_data,
  output logic              o_owt_spi_wack,
  output logic              o_owt_spi_rack,
  output logic [REG_DW-1:0] o_owt_spi_rdata,
  output logic              o_owt_spi_err,
  output logic              o_owt_tx_req,
  output logic              o_owt_tx_cmd,
  output logic [REG_AW-1:0] o_owt_tx_addr,
  output logic [REG_DW-1:0] o_owt_tx_data,
  input  logic              i_owt_tx_ack,
  input  logic              i_owt_rx_vld,
  input  logic              i_owt_rx_cmd,
  input  logic [REG_AW-1:0] i_owt_rx_addr,
  input  logic [REG_DW-1:0] i_owt_rx_data,
  input  logic              i_owt_rx_crc_err
);

  owt_state_e        state, state_nxt;
  logic              cmd_q;
  logic [REG_AW-1:0] addr_q;
  logic [REG_DW-1:0] data_q;
  logic [REG_DW-1:0] rdata_q;
  logic              err_q, err_nxt;
  logic              timeout;
  logic              rx_match;
  logic              rsp_ok;
  logic              rsp_fail;
  logic              retry;

  assign rx_match = (i_owt_rx_cmd == cmd_q) && (i_owt_rx_addr == addr_q) && !i_owt_rx_crc_err;
  // A response strobe always decides the outcome, even in the timeout cycle.
  assign rsp_ok   = (state == ST_WAIT) && i_owt_rx_vld && rx_match;
  assign rsp_fail = (state == ST_WAIT) && (i_owt_rx_vld ? !rx_match : timeout);

  lv_owt_tmo_cnt #(
    .TMO_CYC(TMO_CYC)
  ) u_tmo_cnt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .clear  ((state == ST_TX) && i_owt_tx_ack),
    .enable (state == ST_WAIT),
    .timeout(timeout)
  );

`ifdef LV_OWT_RETRY_EN
  localparam int unsigned RCW = (RETRY_NUM < 1) ? 1 : $clog2(RETRY_NUM + 1);
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(RETRY_NUM);

  logic [RCW-1:0] retry_cnt;

  assign retry = rsp_fail && (retry_cnt < RETRY_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      retry_cnt <= '0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_TX)) begin
      retry_cnt <= '0;
    end else if (retry) begin
      retry_cnt <= retry_cnt + RCW'(1);
    end
  end
`else
  assign retry = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    unique case (state)
      ST_IDLE: if (i_spi_owt_wr_req || i_spi_owt_rd_req) state_nxt = ST_TX;
      ST_TX:   if (i_owt_tx_ack) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rsp_ok) begin
          state_nxt = ST_ACK;
          err_nxt   = 1'b0;
        end else if (retry) begin
          state_nxt = ST_TX;
        end else if (rsp_fail) begin
          state_nxt = ST_ACK;
          err_nxt   = 1'b1;
        end
      end
      ST_ACK:  state_nxt = ST_HOLD;
      ST_HOLD: if (!i_spi_owt_wr_req && !i_spi_owt_rd_req) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if ((state == ST_IDLE) && (i_spi_owt_wr_req || i_spi_owt_rd_req)) begin
        cmd_q  <= i_spi_owt_wr_req ? OWT_CMD_WR : OWT_CMD_RD;
        addr_q <= i_spi_owt_addr;
        data_q <= i_spi_owt_data;
      end
      if (rsp_ok && (cmd_q == OWT_CMD_RD)) rdata_q <= i_owt_rx_data;
    end
  end

  assign o_owt_tx_req    = (state == ST_TX);
  assign o_owt_tx_cmd    = cmd_q;
  assign o_owt_tx_addr   = addr_q;
  assign o_owt_tx_data   = data_q;
  assign o_owt_spi_wack  = (state == ST_ACK) && (cmd_q == OWT_CMD_WR);
  assign o_owt_spi_rack  = (state == ST_ACK) && (cmd_q == OWT_CMD_RD);
  assign o_owt_spi_err   = (state == ST_ACK) && err_q;
  assign o_owt_spi_rdata = rdata_q;

endmodule
